// File: rtl/rca_seq_ctrl_if.sv
// rca_seq_ctrl_if: requester-side bundle for the nibble-serial adder sequencer.
//   start      request pulse (requester -> sequencer)
//   a, b, cin  operands and carry-in, captured on accepted start
//   busy       high while nibbles are being processed
//   done       one-cycle result-valid pulse
//   sum, cout  result and final carry, held until the next accepted start
//   ovf        2's-complement overflow, present only when OVF_EN is defined
// Modports: master = requester, slave = sequencer.
interface rca_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: performs WIDTH-bit additions by stepping one external 4-bit
// ripple-carry slice across the operands, LSB nibble first, one nibble per
// clock, with the inter-nibble carry kept in a register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req (slave)     start/a/b/cin in, busy/done/sum/cout (and ovf) out
//   add_a, add_b    current nibble of the latched operands to the slice
//   add_cin         carry into the slice
//   add_sum         slice sum (combinational from add_a/add_b/add_cin)
//   add_cout        slice carry-out
// Optional feature: OVF_EN adds the 2's-complement overflow output req.ovf.
// The interface instance must be built with the same WIDTH as this module.
module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    rca_seq_ctrl_if.slave req,
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_cin,
    input  logic [3:0]   add_sum,
    input  logic         add_cout
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic             busy_reg;
    logic             done_reg;
    logic             cout_reg;
`ifdef OVF_EN
    logic             ovf_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            cout_reg <= 1'b0;
`ifdef OVF_EN
            ovf_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (req.start) begin
                        a_reg    <= req.a;
                        b_reg    <= req.b;
                        carry    <= req.cin;
                        idx      <= '0;
                        busy_reg <= 1'b1;
`ifdef OVF_EN
                        ovf_reg  <= 1'b0;
`endif
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[4*int'(idx) +: 4] <= add_sum;
                    carry <= add_cout;
                    if (idx == LAST) begin
                        idx      <= '0;
                        cout_reg <= add_cout;
`ifdef OVF_EN
                        // Sign of the result is bit 3 of the top slice's sum.
                        ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                    (add_sum[3] != a_reg[WIDTH-1]);
`endif
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Slice inputs are driven only in RUN so the adder sees zeros otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[4*int'(idx) +: 4];
            add_b   = b_reg[4*int'(idx) +: 4];
            add_cin = carry;
        end
    end

    assign req.busy = busy_reg;
    assign req.done = done_reg;
    assign req.sum  = sum_reg;
    assign req.cout = cout_reg;
`ifdef OVF_EN
    assign req.ovf  = ovf_reg;
`endif

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
Multi-cycle sequencer that performs WIDTH-bit additions by reusing one external 4-bit ripple carry adder slice, one nibble per clock. It works from the LSB nibble to the MSB nibble and carries between nibbles through an internal register. The block sits between a requester using a start/busy/done handshake and a combinational 4-bit RCA instance wired to its add_* ports.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NIB, WIDTH/4, number of nibble steps per operation (derived; not overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  operand A, captured when start is accepted
b  input  WIDTH  operand B, captured when start is accepted
cin  input  1  carry-in, captured when start is accepted
busy  output  1  high while nibbles are being processed (RUN)
done  output  1  one-cycle pulse: sum/cout valid
sum  output  WIDTH  result, held until next accepted start
cout  output  1  final carry-out, held with sum
add_a  output  4  nibble of A to adder slice
add_b  output  4  nibble of B to adder slice
add_cin  output  1  carry into adder slice
add_sum  input  4  slice sum (combinational from add_a/add_b/add_cin)
add_cout  input  1  slice carry-out

Behaviour:
- Reset: one clock, synchronous, active-high on rst; sampled on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, add_a=0, add_b=0, add_cin=0. Internal idx, carry and operand registers are 0.
- FSM states are IDLE, RUN and DONE.
- IDLE: on start=1, latch a, b and cin, set idx=0 and carry=cin, then go to RUN. sum and cout keep their old values until overwritten.
- RUN: busy=1. add_a=a_reg[4*idx+3:4*idx], add_b=b_reg[same], add_cin=carry; all are combinational from registers.
- RUN, each edge: sum[4*idx+3:4*idx]<=add_sum, carry<=add_cout, idx<=idx+1.
- RUN exit: on the edge where idx==NIB-1, cout<=add_cout and go to DONE.
- DONE: done=1 for exactly one cycle and busy=0, then unconditionally return to IDLE.
- add_a, add_b and add_cin are 0 outside RUN.
- Latency: start is sampled at edge k and done is high in the cycle after edge k+NIB. For WIDTH=16 that is 4 cycles from acceptance to the done pulse.
- Throughput: one operation per NIB+2 cycles.
- start during RUN or DONE is ignored and not queued. Operands on a/b/cin may change freely after acceptance.
- Wrap-around: no modulo logic beyond WIDTH bits. The full carry chain appears on cout, e.g. all-ones + 1 gives sum=0, cout=1.
- rst mid-operation: the next cycle is IDLE with all outputs at reset values and the partial sum discarded.
- rst and start high together: rst wins and start is ignored.
- WIDTH=4 degenerate case: a single RUN cycle.

Optional Feature:
Macro OVF_EN.
- Defined: adds output port ovf (1 bit), which is 2's-complement overflow. On the final RUN edge, ovf <= (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (add_sum[3]!=a_reg[WIDTH-1]). It is held with sum, and cleared to 0 by rst and on acceptance of a new start.
- Not defined: no ovf port and no overflow logic; all other behaviour is identical.

Test Plan:
1. Assert rst 2 cycles with start=1 -> busy=0, done=0, sum=0x0000, cout=0, add_a=0, and no operation starts.
2. a=0x0001, b=0x0002, cin=0, start for 1 cycle -> busy high 4 cycles, done pulse 1 cycle, sum=0x0003, cout=0. add_a sequence is 1,0,0,0.
3. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. add_cin sequence is 0,1,1,1.
4. a=0x7777, b=0x7777, cin=1 -> sum=0xEEEF, cout=0. With OVF_EN, ovf=1. Then a=0xE000, b=0xC000, cin=0 -> sum=0xA000, cout=1, ovf=0.
5. Accept a=0x1234, b=0x1111; during RUN pulse start with a=0xFFFF, b=0xFFFF; pulse start again in the DONE cycle -> both ignored, single done, sum=0x2345. A start one cycle after done is accepted.
6. Accept a=0x0F0F, b=0x0101; assert rst after 2 RUN edges -> next cycle IDLE with busy=0, sum=0, done never pulses. Then a=0x0F0F, b=0x0101 -> sum=0x1010, cout=0.
